// File: rtl/spart.sv
// SPART: register-bus serial port with 8N1 TX/RX and a programmable 16x baud enable.
// Bus reads are combinational in the access cycle; TX writes while busy are dropped.
module spart (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        wr, rd;
  logic [7:0]  rd_dat;
  logic [15:0] div, bcnt;
  logic        div_ld, en16;
  logic        ferr;
  logic [7:0]  rx_buf;

  tx_state_t   tx_state;
  logic [9:0]  tx_sh;
  logic [3:0]  tx_tick, tx_bit;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2;
  logic [3:0]  rx_tick;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;

  assign wr = iocs && !iorw;
  assign rd = iocs && iorw;

  always_comb begin
    rd_dat = 8'h00;
    case (ioaddr)
      2'd0:    rd_dat = rx_buf;
      2'd1:    rd_dat = {5'b0, ferr, rda, tbr};
      2'd2:    rd_dat = div[7:0];
      default: rd_dat = div[15:8];
    endcase
  end

  assign databus = rd ? rd_dat : 8'hzz;

  // en16 fires on the cycle bcnt sits at zero, giving a period of div+1 cycles.
  assign en16 = (bcnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= 16'h0145;
      bcnt   <= 16'h0145;
      div_ld <= 1'b0;
    end else begin
      div_ld <= wr && ioaddr[1];
      if (wr && ioaddr == 2'd2) div[7:0]  <= databus;
      if (wr && ioaddr == 2'd3) div[15:8] <= databus;
      if (div_ld || en16) bcnt <= div;
      else                bcnt <= bcnt - 16'd1;
    end
  end

  assign txd = tx_sh[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_sh    <= 10'h3FF;
      tx_tick  <= 4'd0;
      tx_bit   <= 4'd0;
      tbr      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr && ioaddr == 2'd0 && tbr) begin
            tx_sh    <= {1'b1, databus, 1'b0};
            tx_tick  <= 4'd0;
            tx_bit   <= 4'd0;
            tbr      <= 1'b0;
            tx_state <= TX_SHIFT;
          end
        end
        default: begin
          if (en16) begin
            tx_tick <= tx_tick + 4'd1;
            if (tx_tick == 4'd15) begin
              if (tx_bit == 4'd9) begin
                tbr      <= 1'b1;
                tx_state <= TX_IDLE;
              end else begin
                tx_sh  <= {1'b1, tx_sh[9:1]};
                tx_bit <= tx_bit + 4'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tick  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h00;
      rx_buf   <= 8'h00;
      rda      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      if (rd && ioaddr == 2'd0) rda  <= 1'b0;
      if (rd && ioaddr == 2'd1) ferr <= 1'b0;
      // Completion assignments below come later, so a set beats a same-cycle read clear.
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_tick  <= 4'd0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (en16) begin
            if (rx_tick == 4'd7) begin
              rx_tick  <= 4'd0;
              rx_bit   <= 3'd0;
              rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (en16) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == 4'd15) begin
              rx_sh  <= {rx_s2, rx_sh[7:1]};
              rx_bit <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end
          end
        end
        default: begin
          if (en16) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == 4'd15) begin
              if (rx_s2) begin
                rx_buf <= rx_sh;
                rda    <= 1'b1;
              end else begin
                ferr   <= 1'b1;
              end
              rx_state <= RX_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart.sv
// Bench for spart: register bus, baud programming, TX/RX 8N1 frames against a simple frame model.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'd0;
  logic       rxd = 1'b1;
  logic [7:0] tb_dat = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model of the receive-side registers.
  logic       m_rda  = 1'b0;
  logic       m_ferr = 1'b0;
  logic [7:0] m_buf  = 8'h00;

  localparam int BIT_CYC = 64;

  assign databus = tb_drv ? tb_dat : 8'hzz;

  spart dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_status();
    return {5'b0, m_ferr, m_rda, 1'b1};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_drv = 1'b1;
    @(negedge clk);
    iocs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_stop);
    rxd = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    if (good_stop) begin
      rxd = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
    end else begin
      rxd = 1'b0;
      repeat (48) @(negedge clk);
      rxd = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    n_chk++; if (tbr !== 1'b1) $display("FAIL reset_tbr got %b want 1", tbr); else n_pass++;
    n_chk++; if (rda !== 1'b0) $display("FAIL reset_rda got %b want 0", rda); else n_pass++;
    n_chk++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd1, d);
    n_chk++; if (d !== 8'h01) $display("FAIL reset_status got %h want 01", d); else n_pass++;
    bus_read(2'd2, d);
    n_chk++; if (d !== 8'h45) $display("FAIL reset_div_lo got %h want 45", d); else n_pass++;
    bus_read(2'd3, d);
    n_chk++; if (d !== 8'h01) $display("FAIL reset_div_hi got %h want 01", d); else n_pass++;
  endtask

  task automatic test_baud();
    logic [7:0] d;
    int gap;
    bus_write(2'd2, 8'h03);
    bus_write(2'd3, 8'h00);
    bus_read(2'd2, d);
    n_chk++; if (d !== 8'h03) $display("FAIL baud_div_lo got %h want 03", d); else n_pass++;
    gap = 0;
    while (!dut.en16 && gap < 20) begin @(negedge clk); gap++; end
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!dut.en16 && gap < 50);
      n_chk++; if (gap != 4) $display("FAIL baud_period got %0d cycles want 4", gap); else n_pass++;
    end
  endtask

  task automatic test_tx(input logic [7:0] b);
    logic [9:0]   frame;
    logic [759:0] s_txd, s_tbr;
    int t, lows, drops;
    frame = {1'b1, b, 1'b0};
    bus_write(2'd0, b);
    n_chk++; if (tbr !== 1'b0) $display("FAIL tx_tbr_fall got %b want 0", tbr); else n_pass++;
    n_chk++; if (txd !== 1'b0) $display("FAIL tx_start got %b want 0", txd); else n_pass++;
    for (int c = 0; c < 760; c++) begin
      s_txd[c] = txd;
      s_tbr[c] = tbr;
      if (c == 100) begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'd0; tb_dat = ~b; tb_drv = 1'b1;
      end else if (c == 101) begin
        iocs = 1'b0; tb_drv = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (s_txd[BIT_CYC*i+32] !== frame[i])
        $display("FAIL tx_bit%0d byte %h got %b want %b", i, b, s_txd[BIT_CYC*i+32], frame[i]);
      else n_pass++;
    end
    t = -1;
    for (int c = 0; c < 760; c++) if (t < 0 && s_tbr[c]) t = c;
    n_chk++;
    if (t < 636 || t > 644) $display("FAIL tx_frame_len got %0d cycles want 640+-4", t);
    else n_pass++;
    lows = 0; drops = 0;
    if (t >= 0)
      for (int c = t; c < 760; c++) begin
        if (!s_txd[c]) lows++;
        if (!s_tbr[c]) drops++;
      end
    n_chk++;
    if (lows != 0 || drops != 0)
      $display("FAIL tx_busy_write_dropped got %0d low/%0d busy cycles want 0/0", lows, drops);
    else n_pass++;
  endtask

  task automatic test_rx(input logic [7:0] b);
    logic [7:0] d;
    send_frame(b, 1'b1);
    m_buf = b; m_rda = 1'b1;
    n_chk++; if (rda !== m_rda) $display("FAIL rx_rda got %b want %b", rda, m_rda); else n_pass++;
    bus_read(2'd0, d);
    n_chk++; if (d !== m_buf) $display("FAIL rx_data got %h want %h", d, m_buf); else n_pass++;
    m_rda = 1'b0;
    n_chk++; if (rda !== m_rda) $display("FAIL rx_rda_clear got %b want %b", rda, m_rda); else n_pass++;
  endtask

  task automatic test_ferr_glitch();
    logic [7:0] d, e;
    send_frame(8'($urandom), 1'b0);
    m_ferr = 1'b1;
    n_chk++; if (rda !== m_rda) $display("FAIL ferr_rda got %b want %b", rda, m_rda); else n_pass++;
    e = exp_status();
    bus_read(2'd1, d);
    n_chk++; if (d !== e) $display("FAIL ferr_status got %h want %h", d, e); else n_pass++;
    m_ferr = 1'b0;
    e = exp_status();
    bus_read(2'd1, d);
    n_chk++; if (d !== e) $display("FAIL ferr_clear got %h want %h", d, e); else n_pass++;
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (700) @(negedge clk);
    n_chk++; if (rda !== m_rda) $display("FAIL glitch_rda got %b want %b", rda, m_rda); else n_pass++;
    e = exp_status();
    bus_read(2'd1, d);
    n_chk++; if (d !== e) $display("FAIL glitch_status got %h want %h", d, e); else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    m_buf = 8'h22; m_rda = 1'b1;
    n_chk++; if (rda !== m_rda) $display("FAIL overrun_rda got %b want %b", rda, m_rda); else n_pass++;
    bus_read(2'd0, d);
    n_chk++; if (d !== m_buf) $display("FAIL overrun_data got %h want %h", d, m_buf); else n_pass++;
    m_rda = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, y, d;
    int r;
    x = 8'($urandom);
    y = x ^ 8'(1 + $urandom_range(0, 254));
    r = -1;
    fork
      begin
        send_frame(x, 1'b1);
        send_frame(y, 1'b1);
      end
      begin
        for (int c = 1; c <= 10*BIT_CYC; c++) begin
          @(negedge clk);
          if (rda && r < 0) r = c;
        end
        n_chk++;
        if (r < 2) $display("FAIL b2b_first_done got %0d want rise inside frame", r);
        else begin
          n_pass++;
          // Frames are whole multiples of the en16 period, so the second completes r cycles into it.
          repeat (r - 1) @(negedge clk);
          iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
          #1 d = databus;
          @(negedge clk);
          iocs = 1'b0; iorw = 1'b0;
          n_chk++; if (d !== x) $display("FAIL b2b_old_byte got %h want %h", d, x); else n_pass++;
          n_chk++; if (rda !== 1'b1) $display("FAIL b2b_rda_kept got %b want 1", rda); else n_pass++;
        end
      end
    join
    m_buf = y; m_rda = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(2'd0, d);
    n_chk++; if (d !== m_buf) $display("FAIL b2b_new_byte got %h want %h", d, m_buf); else n_pass++;
    m_rda = 1'b0;
    n_chk++; if (rda !== m_rda) $display("FAIL b2b_rda_clear got %b want %b", rda, m_rda); else n_pass++;
  endtask

  task automatic test_rst_abort();
    logic [7:0] d;
    bus_write(2'd0, 8'h00);
    repeat (50) @(negedge clk);
    n_chk++; if (txd !== 1'b0) $display("FAIL abort_inflight got %b want 0", txd); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (txd !== 1'b1) $display("FAIL abort_txd got %b want 1", txd); else n_pass++;
    n_chk++; if (tbr !== 1'b1) $display("FAIL abort_tbr got %b want 1", tbr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd3, d);
    n_chk++; if (d !== 8'h01) $display("FAIL abort_div_hi got %h want 01", d); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_baud();
    test_tx(8'hA5);
    for (int k = 0; k < 2; k++) test_tx(8'($urandom));
    test_rx(8'h3C);
    for (int k = 0; k < 2; k++) test_rx(8'($urandom));
    test_ferr_glitch();
    test_overrun();
    test_back_to_back();
    test_rst_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
